// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic number generator bank.
// Holds the FSM state type, the burst-length helper and the LFSR tap table.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sng_state_t;

  // Burst length L: one bit per nonzero LFSR state.
  function automatic int sc_len(input int width);
    return (1 << width) - 1;
  endfunction

  // Fibonacci tap masks (bit k-1 set for term x^k); all polynomials are primitive.
  function automatic logic [7:0] lfsr_taps(input int width);
    case (width)
      3:       return 8'b0000_0110;  // x^3+x^2+1
      4:       return 8'b0000_1100;  // x^4+x^3+1
      5:       return 8'b0001_0100;  // x^5+x^3+1
      6:       return 8'b0011_0000;  // x^6+x^5+1
      7:       return 8'b0110_0000;  // x^7+x^6+1
      8:       return 8'b1011_1000;  // x^8+x^6+x^5+x^4+1
      default: return 8'b0000_1100;
    endcase
  endfunction

endpackage

// File: rtl/sc_sng_bank_if.sv
// Operand/burst handshake bundle between the SNG bank and its neighbours.
// master drives operands and control, slave is the generator bank.
interface sc_sng_bank_if #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_INPUTS = 2
);

  logic                                  start;
  logic                                  en;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] bin_data_in;
  logic                                  busy;
  logic                                  sc_valid;
  logic [NUM_INPUTS-1:0]                 sc_bits;
  logic                                  done;

  modport master (
    output start, en, bin_data_in,
    input  busy, sc_valid, sc_bits, done
  );

  modport slave (
    input  start, en, bin_data_in,
    output busy, sc_valid, sc_bits, done
  );

endinterface

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR shared by every stream of the SNG bank.
// A zero seed is replaced by 1 so the register can never lock up at 0.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  localparam logic [7:0]       TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LOAD_VAL = (SEED_W == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED_W;

  logic fb;

  assign fb = ^(state & TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD_VAL;
    end else if (load) begin
      state <= LOAD_VAL;
    end else if (step) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/sc_sng_bank.sv
// Stochastic number generator bank: latches operands and emits L-bit unipolar streams.
// Optional SC_SNG_DECORR_EN rotates the shared random word per stream to decorrelate them.
module sc_sng_bank
  import sc_pkg::*;
#(
  parameter int          DATA_WIDTH = 4,
  parameter int          NUM_INPUTS = 2,
  parameter int unsigned LFSR_SEED  = 1
) (
  input logic          clk,
  input logic          rst,
  sc_sng_bank_if.slave bus
);

  localparam int                    L    = sc_len(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LAST = L[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  sng_state_t                            state;
  sng_state_t                            next_state;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ops_p0;
  logic [DATA_WIDTH-1:0]                 cnt;
  logic [DATA_WIDTH-1:0]                 rnd;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] rnd_rot;
  logic [NUM_INPUTS-1:0]                 cmp;
  logic                                  accept;
  logic                                  advance;
  logic                                  vld_p1;
  logic [NUM_INPUTS-1:0]                 bits_p1;

  // cnt counts emitted bits; reaching L means the burst is complete.
  assign accept  = (state == IDLE) && bus.start;
  assign advance = (state == RUN) && bus.en && (cnt != LAST);

  sc_lfsr #(
    .WIDTH (DATA_WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (advance),
    .state (rnd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + ONE;
    end
  end

  // p0: operand latch, captured only on the accepting start edge
  always_ff @(posedge clk) begin
    if (accept) begin
      ops_p0 <= bus.bin_data_in;
    end
  end

  // Rotation is a bit permutation of a nonzero word, so each stream still sees 1..L once.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_stream
`ifdef SC_SNG_DECORR_EN
    localparam int R = i % DATA_WIDTH;
    if (R == 0) begin : g_norot
      assign rnd_rot[i] = rnd;
    end else begin : g_rot
      assign rnd_rot[i] = {rnd[DATA_WIDTH-1-R:0], rnd[DATA_WIDTH-1:DATA_WIDTH-R]};
    end
`else
    assign rnd_rot[i] = rnd;
`endif
    assign cmp[i] = (rnd_rot[i] <= ops_p0[i]);
  end

  // p1: registered comparator outputs; bits hold while paused
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      bits_p1 <= '0;
    end else begin
      vld_p1 <= advance;
      if (advance) begin
        bits_p1 <= cmp;
      end
    end
  end

  assign bus.sc_valid = vld_p1;
  assign bus.sc_bits  = bits_p1;

endmodule
